div_sequencer: RTL and testbench

- Multi-cycle radix-2 restoring divider with its own sequencing FSM for the EX stage.
- Executes DIV/DIVU: produces {remainder, quotient} for the HI/LO write path.
- Start/ready handshake pairs with the hazard unit's div_start/div_ready stall logic: EX holds start high until ready, and the pipeline stalls meanwhile.
- annul lets exception/flush logic cancel an in-flight divide.

---
 rtl/div_sequencer.sv | 149 ++++++++++++++
 tb/tb_div_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} for the HI/LO write path under a start/ready handshake.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DZERO = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               sign1, sign2;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     trial, diff;
    logic               take;
    logic [WIDTH-1:0]   rem_next, quot_next;
    logic [WIDTH-1:0]   rem_fix, quot_fix;

    // Magnitudes of the incoming operands (only negated for a signed divide).
    assign sign1 = signed_div & opdata1[WIDTH-1];
    assign sign2 = signed_div & opdata2[WIDTH-1];
    assign abs1  = sign1 ? -opdata1 : opdata1;
    assign abs2  = sign2 ? -opdata2 : opdata2;

    // The trial remainder keeps one extra bit so divisors with the MSB set divide correctly.
    assign trial     = {rem_q, quot_q[WIDTH-1]};
    assign diff      = trial - {1'b0, divisor_q};
    assign take      = ~diff[WIDTH];
    assign rem_next  = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot_next = {quot_q[WIDTH-2:0], take};
    assign rem_fix   = rneg_q ? -rem_next : rem_next;
    assign quot_fix  = qneg_q ? -quot_next : quot_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (!annul && start) begin
                    if (opdata2 == '0) begin
                        state_d = S_DZERO;
                        quot_d  = opdata1;
                    end else begin
                        state_d   = S_BUSY;
                        quot_d    = abs1;
                        divisor_d = abs2;
                        qneg_d    = sign1 ^ sign2;
                        rneg_d    = sign1;
                        rem_d     = '0;
                        cnt_d     = '0;
                    end
                end
            end
            S_BUSY: begin
                rem_d  = rem_next;
                quot_d = quot_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_DONE;
                    result_d = {rem_fix, quot_fix};
                end
            end
            S_DZERO: begin
                state_d  = S_DONE;
                result_d = {quot_q, {WIDTH{1'b1}}};
            end
            S_DONE: begin
                // Holding start keeps us here so one request never launches two divides.
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (annul) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end

        ready_d = (state_d == S_DONE);
        busy_d  = (state_d == S_BUSY) || (state_d == S_DZERO);
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer against an arithmetic divide model.
// Latency counts the start-sampling edge as edge 1 (33 for a divide, 2 for divide-by-zero).
`timescale 1ns/1ps
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int          tests;
    int          fails;
    logic [63:0] exp_result;
    logic [63:0] last_res;

    div_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: plain integer division; quotient truncates toward zero, remainder follows dividend.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sd) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Invariants and result check on every cycle the outputs are meaningful.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_busy_exclusive", 64'(ready & busy), 64'd0);
            if (ready) chk("result_when_ready", result, exp_result);
        end
    end

    task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b, input int hold);
        int edges;
        int busy_cnt;
        logic [63:0] expv;
        expv       = model(sd, a, b);
        exp_result = expv;
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        edges      = 0;
        busy_cnt   = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (busy) busy_cnt++;
        end while (!ready && edges < 100);
        $display("[TB] op sd=%0d %h / %h -> %h (edges=%0d)", sd, a, b, result, edges);
        chk("latency_edges", 64'(edges), (b == 32'd0) ? 64'd2 : 64'd33);
        chk("busy_cycles", 64'(busy_cnt), (b == 32'd0) ? 64'd1 : 64'd32);
        chk("result", result, expv);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("ready_held_with_start", 64'(ready), 64'd1);
            chk("no_restart_busy", 64'(busy), 64'd0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("ready_drop_after_start_low", 64'(ready), 64'd0);
        chk("result_held_in_idle", result, expv);
        last_res = expv;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b;
        logic        sd;
        tests      = 0;
        fails      = 0;
        exp_result = '0;
        last_res   = '0;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;

        // Model pinned by hand-computed values.
        chk("model_divu_100_7", model(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_div_m7_2", model(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_div_7_m2", model(1'b1, 32'd7, 32'hFFFF_FFFE), {32'h0000_0001, 32'hFFFF_FFFD});
        chk("model_dzero", model(1'b0, 32'h1234, 32'd0), {32'h0000_1234, 32'hFFFF_FFFF});
        chk("model_overflow", model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
        chk("model_divu_big", model(1'b0, 32'hFFFF_FFFF, 32'h10), {32'hF, 32'h0FFF_FFFF});

        repeat (2) @(negedge clk);
        chk("reset_result", result, 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(1'b0, 32'h1234, 32'd0, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);

        // Annul at iteration 10: no completion, result untouched, annul+start in IDLE stays idle.
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        $display("[TB] annul mid-divide: ready=%0d busy=%0d result=%h", ready, busy, result);
        chk("annul_busy", 64'(busy), 64'd0);
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result_held", result, last_res);
        @(negedge clk);
        chk("annul_start_idle_busy", 64'(busy), 64'd0);
        chk("annul_start_idle_ready", 64'(ready), 64'd0);
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 0);

        // Asynchronous reset between edges in the middle of a divide.
        @(negedge clk);
        start   = 1'b1;
        opdata1 = 32'd12345;
        opdata2 = 32'd17;
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        $display("[TB] async reset mid-divide: ready=%0d busy=%0d result=%h", ready, busy, result);
        chk("async_rst_result", result, 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_ready", 64'(ready), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_busy", 64'(busy), 64'd0);

        for (int n = 0; n < 20; n++) begin
            sd = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(sd, a, b, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
